// File: rtl/mc_eject_unit_pkg.sv
// Shared destination-list definitions for the multicast eject path.
// Holds the global destination-list width, the per-port field masks and a
// small helper used to test whether a list selects any port under a mask.
package mc_eject_unit_pkg;

  localparam int unsigned DST_LIST_WIDTH = 15;
  localparam int unsigned NUM_PORT       = 5;

  typedef logic [DST_LIST_WIDTH-1:0] dst_list_t;

  // Three destination bits per port: N, E, S, W, then the local field on top.
  localparam dst_list_t N_MASK = 15'h0007;
  localparam dst_list_t E_MASK = 15'h0038;
  localparam dst_list_t S_MASK = 15'h01C0;
  localparam dst_list_t W_MASK = 15'h0E00;
  localparam dst_list_t L_MASK = 15'h7000;

  function automatic logic dst_hits(input dst_list_t dst, input dst_list_t mask);
    return |(dst & mask);
  endfunction

endpackage

// File: rtl/mc_eject_fifo.sv
// Circular-buffer ejection FIFO.
// Ports: clk/rst_n (async active-low), push/push_data write the tail,
// pop removes the head, head is the oldest entry, full/empty/count status.
// A push while full is honoured only if a pop happens in the same cycle;
// a pop while empty is ignored. No fall-through: a push into an empty FIFO
// becomes visible on head the following cycle.
module mc_eject_fifo #(
  parameter int unsigned FLIT_W   = 64,
  parameter int unsigned EJ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic [FLIT_W-1:0]           push_data,
  input  logic                        pop,
  output logic [FLIT_W-1:0]           head,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(EJ_DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(EJ_DEPTH);

  logic [FLIT_W-1:0] mem_q [EJ_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q;
  logic              do_push, do_pop;

  assign full    = (count_q == EJ_DEPTH[AW:0]);
  assign empty   = (count_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointers are AW bits wide, so power-of-two depth wraps for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(EJ_DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/mc_eject_unit.sv
// Multicast eject unit: splits an incoming flit into at most one local
// delivery (ejection FIFO) and at most one onward flit (forward register).
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   in_valid/in_ready/in_flit/in_dst input flit with destination list
//   fwd_valid/fwd_ready/fwd_flit/fwd_dst  registered onward flit, L field cleared
//   ej_valid/ej_ready/ej_flit/ej_count    ejection FIFO head and occupancy
//   ej_total                         saturating count of ejected flits
//   err_null_dst                     pulse after accepting an empty list
module mc_eject_unit #(
  parameter int unsigned FLIT_W                    = 64,
  parameter int unsigned DST_LIST_WIDTH            = mc_eject_unit_pkg::DST_LIST_WIDTH,
  parameter logic [DST_LIST_WIDTH-1:0] L_MASK      = mc_eject_unit_pkg::L_MASK,
  parameter int unsigned EJ_DEPTH                  = 4,
  parameter int unsigned CNT_W                     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [FLIT_W-1:0]           in_flit,
  input  logic [DST_LIST_WIDTH-1:0]   in_dst,
  output logic                        fwd_valid,
  input  logic                        fwd_ready,
  output logic [FLIT_W-1:0]           fwd_flit,
  output logic [DST_LIST_WIDTH-1:0]   fwd_dst,
  output logic                        ej_valid,
  input  logic                        ej_ready,
  output logic [FLIT_W-1:0]           ej_flit,
  output logic [$clog2(EJ_DEPTH):0]   ej_count,
  output logic [CNT_W-1:0]            ej_total,
  output logic                        err_null_dst
);

  import mc_eject_unit_pkg::*;

  logic                      need_ej, need_fwd;
  logic [DST_LIST_WIDTH-1:0] rem;
  logic                      ej_full, ej_empty, ej_pop, ej_push;
  logic                      ej_ok, fwd_ok, accept;

  logic                      fwd_valid_q;
  logic [FLIT_W-1:0]         fwd_flit_q;
  logic [DST_LIST_WIDTH-1:0] fwd_dst_q;
  logic [CNT_W-1:0]          ej_total_q;
  logic                      err_null_q;

  assign need_ej  = dst_hits(in_dst, L_MASK);
  assign rem      = in_dst & ~L_MASK;
  assign need_fwd = |rem;

  // A full FIFO still has room when its head leaves this cycle.
  assign ej_pop   = ej_valid & ej_ready;
  assign ej_ok    = ~ej_full | ej_pop;
  assign fwd_ok   = ~fwd_valid_q | fwd_ready;

  // Both resources must be available before anything is taken.
  assign in_ready = (~need_ej | ej_ok) & (~need_fwd | fwd_ok);
  assign accept   = in_valid & in_ready;
  assign ej_push  = accept & need_ej;

  mc_eject_fifo #(
    .FLIT_W   (FLIT_W),
    .EJ_DEPTH (EJ_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (ej_push),
    .push_data (in_flit),
    .pop       (ej_pop),
    .head      (ej_flit),
    .full      (ej_full),
    .empty     (ej_empty),
    .count     (ej_count)
  );

  assign ej_valid = ~ej_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_valid_q <= 1'b0;
      fwd_flit_q  <= '0;
      fwd_dst_q   <= '0;
      ej_total_q  <= '0;
      err_null_q  <= 1'b0;
    end else begin
      // A new load takes priority over a drain, giving back-to-back forwards.
      if (accept && need_fwd) begin
        fwd_valid_q <= 1'b1;
        fwd_flit_q  <= in_flit;
        fwd_dst_q   <= rem;
      end else if (fwd_valid_q && fwd_ready) begin
        fwd_valid_q <= 1'b0;
      end
      if (ej_push && (ej_total_q != '1)) ej_total_q <= ej_total_q + 1'b1;
      err_null_q <= accept & (in_dst == '0);
    end
  end

  assign fwd_valid    = fwd_valid_q;
  assign fwd_flit     = fwd_flit_q;
  assign fwd_dst      = fwd_dst_q;
  assign ej_total     = ej_total_q;
  assign err_null_dst = err_null_q;

endmodule

// File: tb/tb_mc_eject_unit.sv
module tb_mc_eject_unit;

  localparam logic [14:0] LM = 15'h7000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_flit = '0;
  logic [14:0] in_dst = '0;
  logic        fwd_valid;
  logic        fwd_ready = 1'b0;
  logic [63:0] fwd_flit;
  logic [14:0] fwd_dst;
  logic        ej_valid;
  logic        ej_ready = 1'b0;
  logic [63:0] ej_flit;
  logic [2:0]  ej_count;
  logic [15:0] ej_total;
  logic        err_null_dst;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_total = 0;
  bit rand_en  = 1'b0;

  logic [63:0] ej_q[$];
  logic [63:0] fwd_flit_q[$];
  logic [14:0] fwd_dst_q[$];

  mc_eject_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_flit      (in_flit),
    .in_dst       (in_dst),
    .fwd_valid    (fwd_valid),
    .fwd_ready    (fwd_ready),
    .fwd_flit     (fwd_flit),
    .fwd_dst      (fwd_dst),
    .ej_valid     (ej_valid),
    .ej_ready     (ej_ready),
    .ej_flit      (ej_flit),
    .ej_count     (ej_count),
    .ej_total     (ej_total),
    .err_null_dst (err_null_dst)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Scoreboard: compare every completed handshake against the queued expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ej_valid && ej_ready) begin
        if (ej_q.size() == 0) check_eq("ej_unexpected", 64'(ej_q.size()), 64'd1);
        else check_eq("ej_flit", ej_flit, ej_q.pop_front());
      end
      if (fwd_valid && fwd_ready) begin
        if (fwd_flit_q.size() == 0) check_eq("fwd_unexpected", 64'(fwd_flit_q.size()), 64'd1);
        else begin
          check_eq("fwd_flit", fwd_flit, fwd_flit_q.pop_front());
          check_eq("fwd_dst", 64'(fwd_dst), 64'(fwd_dst_q.pop_front()));
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_en) begin
        ej_ready  = 1'($urandom_range(0, 1));
        fwd_ready = 1'($urandom_range(0, 1));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Present one flit, wait (bounded) for acceptance, record expectations.
  task automatic send(input logic [63:0] f, input logic [14:0] d);
    int n;
    bit ok;
    in_valid = 1'b1;
    in_flit  = f;
    in_dst   = d;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 200) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      n++;
    end
    if (!ok) check_eq("send_timeout", 64'(in_ready), 64'd1);
    else begin
      if ((d & LM) != 0) begin
        ej_q.push_back(f);
        if (exp_total < 65535) exp_total++;
      end
      if ((d & ~LM) != 0) begin
        fwd_flit_q.push_back(f);
        fwd_dst_q.push_back(d & ~LM);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain_ej();
    int n;
    ej_ready = 1'b1;
    n = 0;
    while (ej_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    ej_ready = 1'b0;
    check_eq("drain_ej_count", 64'(ej_count), 64'd0);
  endtask

  initial begin
    logic [14:0] dst_tab [6];
    dst_tab = '{15'h1000, 15'h1013, 15'h0204, 15'h0001, 15'h6000, 15'h4e3f};

    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_fwd_valid", 64'(fwd_valid), 64'd0);
    check_eq("rst_fwd_dst", 64'(fwd_dst), 64'd0);
    check_eq("rst_ej_valid", 64'(ej_valid), 64'd0);
    check_eq("rst_ej_count", 64'(ej_count), 64'd0);
    check_eq("rst_ej_total", 64'(ej_total), 64'd0);
    check_eq("rst_err", 64'(err_null_dst), 64'd0);
    @(posedge clk);
    #1;
    fwd_ready = 1'b1;

    // Unicast local
    send(64'hA5, 15'h1000);
    @(negedge clk);
    check_eq("uni_ej_valid", 64'(ej_valid), 64'd1);
    check_eq("uni_ej_flit", ej_flit, 64'hA5);
    check_eq("uni_fwd_valid", 64'(fwd_valid), 64'd0);
    check_eq("uni_ej_total", 64'(ej_total), 64'(exp_total));
    @(posedge clk);
    #1;
    drain_ej();

    // Multicast split
    send(64'hBEEF, 15'h1013);
    @(negedge clk);
    check_eq("mc_ej_valid", 64'(ej_valid), 64'd1);
    check_eq("mc_fwd_valid", 64'(fwd_valid), 64'd1);
    check_eq("mc_fwd_dst", 64'(fwd_dst), 64'h0013);
    @(posedge clk);
    #1;
    drain_ej();

    // Pure forward
    send(64'hC0DE, 15'h0204);
    @(negedge clk);
    check_eq("pf_fwd_dst", 64'(fwd_dst), 64'h0204);
    check_eq("pf_ej_count", 64'(ej_count), 64'd0);
    check_eq("pf_ej_valid", 64'(ej_valid), 64'd0);
    @(posedge clk);
    #1;

    // FIFO full, pop only, pop+push
    ej_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h100 + 64'(i), 15'h1000);
    @(negedge clk);
    check_eq("full_count", 64'(ej_count), 64'd4);
    in_valid = 1'b1;
    in_flit  = 64'h104;
    in_dst   = 15'h1000;
    #1;
    check_eq("full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ej_ready = 1'b1;
    @(posedge clk);
    #1;
    ej_ready = 1'b0;
    @(negedge clk);
    check_eq("pop_count", 64'(ej_count), 64'd3);
    check_eq("pop_head", ej_flit, 64'h101);
    @(posedge clk);
    #1;
    send(64'h104, 15'h1000);
    ej_ready = 1'b1;
    send(64'h105, 15'h1000);
    ej_ready = 1'b0;
    @(negedge clk);
    check_eq("popush_count", 64'(ej_count), 64'd4);
    check_eq("popush_total", 64'(ej_total), 64'(exp_total));
    @(posedge clk);
    #1;
    drain_ej();

    // Forward stall and atomicity
    fwd_ready = 1'b0;
    send(64'h200, 15'h0002);
    in_valid = 1'b1;
    in_flit  = 64'h201;
    in_dst   = 15'h1002;
    #1;
    check_eq("stall_in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    check_eq("stall_fwd_hold", fwd_flit, 64'h200);
    @(posedge clk);
    #1;
    check_eq("stall_no_push", 64'(ej_count), 64'd0);
    fwd_ready = 1'b1;
    send(64'h201, 15'h1002);
    @(negedge clk);
    check_eq("b2b_fwd_valid", 64'(fwd_valid), 64'd1);
    check_eq("b2b_fwd_flit", fwd_flit, 64'h201);
    @(posedge clk);
    #1;
    drain_ej();

    // Null destination list
    send(64'h300, 15'h0000);
    @(negedge clk);
    check_eq("null_err", 64'(err_null_dst), 64'd1);
    check_eq("null_fwd_valid", 64'(fwd_valid), 64'd0);
    check_eq("null_ej_valid", 64'(ej_valid), 64'd0);
    @(negedge clk);
    check_eq("null_err_pulse", 64'(err_null_dst), 64'd0);
    @(posedge clk);
    #1;

    // Random traffic with random back-pressure
    rand_en = 1'b1;
    for (int i = 0; i < 40; i++) send(64'h1000 + 64'(i), dst_tab[$urandom_range(0, 5)]);
    @(posedge clk);
    #1;
    rand_en   = 1'b0;
    ej_ready  = 1'b1;
    fwd_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("rand_ej_left", 64'(ej_q.size()), 64'd0);
    check_eq("rand_fwd_left", 64'(fwd_flit_q.size()), 64'd0);
    check_eq("rand_total", 64'(ej_total), 64'(exp_total));

    // Reset mid-operation
    ej_ready  = 1'b0;
    fwd_ready = 1'b0;
    send(64'h400, 15'h1000);
    send(64'h401, 15'h1000);
    send(64'h402, 15'h0001);
    @(negedge clk);
    check_eq("pre_rst_count", 64'(ej_count), 64'd2);
    check_eq("pre_rst_fwd", 64'(fwd_valid), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_fwd_valid", 64'(fwd_valid), 64'd0);
    check_eq("arst_fwd_flit", fwd_flit, 64'd0);
    check_eq("arst_ej_valid", 64'(ej_valid), 64'd0);
    check_eq("arst_ej_count", 64'(ej_count), 64'd0);
    check_eq("arst_ej_total", 64'(ej_total), 64'd0);
    ej_q.delete();
    fwd_flit_q.delete();
    fwd_dst_q.delete();
    exp_total = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
